// File: rtl/vga_pkg.sv
// Shared constants for the VGA display engine: default 640x480@60 geometry,
// a small colour palette and the axis-total helper.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_N_LAYERS = 4;
  localparam int DEF_COLOR_W  = 12;
  localparam int DEF_CNT_W    = 10;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] BLUE   = 12'h00F;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] YELLOW = 12'hFF0;

  function automatic int axis_total(input int sync_w, input int bp_w,
                                    input int act_w, input int fp_w);
    return sync_w + bp_w + act_w + fp_w;
  endfunction

endpackage

// File: rtl/vga_display_engine_if.sv
// Renderer/pin bundle of the display engine: timing and pixel outputs
// towards renderers and pins, fill/palette/blank inputs from renderers.
interface vga_display_engine_if
  import vga_pkg::*;
#(
  parameter int N_LAYERS = DEF_N_LAYERS,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int CNT_W    = DEF_CNT_W
);
  logic                         blank_req;
  logic [N_LAYERS-1:0]          fill;
  logic [N_LAYERS*COLOR_W-1:0]  layer_color;
  logic                         pix_en;
  logic [CNT_W-1:0]             hCount;
  logic [CNT_W-1:0]             vCount;
  logic [CNT_W-1:0]             pix_x;
  logic [CNT_W-1:0]             pix_y;
  logic                         active;
  logic                         line_start;
  logic                         frame_start;
  logic                         hSync;
  logic                         vSync;
  logic                         bright;
  logic [COLOR_W-1:0]           rgb;

  modport master (
    input  blank_req, fill, layer_color,
    output pix_en, hCount, vCount, pix_x, pix_y, active,
           line_start, frame_start, hSync, vSync, bright, rgb
  );

  modport slave (
    output blank_req, fill, layer_color,
    input  pix_en, hCount, vCount, pix_x, pix_y, active,
           line_start, frame_start, hSync, vSync, bright, rgb
  );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter for one display axis; wrap_out flags the
// enabled cycle on which the count returns to zero.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = 800,
  parameter int CNT_W = DEF_CNT_W
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             wrap_out,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_r;

  // Advance on enable, wrapping after the last position.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= CNT_W'(0);
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= CNT_W'(0);
      end else begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign wrap_out = en && (count_r == LAST);
  assign count    = count_r;
endmodule

// File: rtl/vga_display_engine.sv
// Parametrised VGA timing generator with a priority layer/palette merge and
// one pixel of registered, mutually aligned sync/bright/rgb output.
module vga_display_engine
  import vga_pkg::*;
#(
  parameter int                 CLK_DIV  = DEF_CLK_DIV,
  parameter int                 H_SYNC   = DEF_H_SYNC,
  parameter int                 H_BP     = DEF_H_BP,
  parameter int                 H_ACTIVE = DEF_H_ACTIVE,
  parameter int                 H_FP     = DEF_H_FP,
  parameter int                 V_SYNC   = DEF_V_SYNC,
  parameter int                 V_BP     = DEF_V_BP,
  parameter int                 V_ACTIVE = DEF_V_ACTIVE,
  parameter int                 V_FP     = DEF_V_FP,
  parameter bit                 SYNC_POL = 1'b0,
  parameter int                 N_LAYERS = DEF_N_LAYERS,
  parameter int                 COLOR_W  = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(BLACK),
  parameter int                 CNT_W    = DEF_CNT_W
)(
  input logic                   clk,
  input logic                   reset,
  vga_display_engine_if.master  bus
);
  localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_total_chk
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_total_chk
    $error("V_TOTAL does not fit in CNT_W bits");
  end
  if (CLK_DIV < 1 || N_LAYERS < 1 || N_LAYERS > 8) begin : g_param_chk
    $error("CLK_DIV must be >= 1 and N_LAYERS within 1..8");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic             SYNC_ON   = SYNC_POL;
  localparam logic             SYNC_OFF  = !SYNC_POL;

  logic               run_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic               pix_en_s;
  logic               h_wrap_s;
  logic               v_wrap_unused_s;
  logic [CNT_W-1:0]   h_cnt_s;
  logic [CNT_W-1:0]   v_cnt_s;
  logic               active_s;
  logic [COLOR_W-1:0] layer_s;
  logic [COLOR_W-1:0] rgb_next_s;
  logic               hsync_r;
  logic               vsync_r;
  logic               bright_r;
  logic [COLOR_W-1:0] rgb_r;

  // Pixel divider; run_r idles it for one clk after reset so pix_en is low
  // in the reset cycle even when CLK_DIV is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r     <= 1'b0;
      div_cnt_r <= DIV_W'(0);
    end else begin
      run_r <= 1'b1;
      if (!run_r || div_cnt_r == DIV_LAST) begin
        div_cnt_r <= DIV_W'(0);
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end
  end

  assign pix_en_s = run_r && (div_cnt_r == DIV_LAST);

  vga_axis_counter #(.TOTAL(H_TOTAL), .CNT_W(CNT_W)) u_h_axis (
    .clk(clk), .reset(reset), .en(pix_en_s), .wrap_out(h_wrap_s), .count(h_cnt_s)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .CNT_W(CNT_W)) u_v_axis (
    .clk(clk), .reset(reset), .en(h_wrap_s), .wrap_out(v_wrap_unused_s), .count(v_cnt_s)
  );

  assign active_s = (h_cnt_s >= H_START_C) && (h_cnt_s <= H_END_C) &&
                    (v_cnt_s >= V_START_C) && (v_cnt_s <= V_END_C);

  // Priority merge: scanning from the top index down leaves the lowest set fill bit winning.
  always_comb begin
    layer_s = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (bus.fill[i]) begin
        layer_s = bus.layer_color[i*COLOR_W +: COLOR_W];
      end else begin
        layer_s = layer_s;
      end
    end
    if (!active_s || bus.blank_req) begin
      rgb_next_s = COLOR_W'(0);
    end else begin
      rgb_next_s = layer_s;
    end
  end

  // Output stage: all pin-facing registers step together on pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_r  <= SYNC_OFF;
      vsync_r  <= SYNC_OFF;
      bright_r <= 1'b0;
      rgb_r    <= COLOR_W'(0);
    end else if (pix_en_s) begin
      hsync_r  <= (h_cnt_s < H_SYNC_C) ? SYNC_ON : SYNC_OFF;
      vsync_r  <= (v_cnt_s < V_SYNC_C) ? SYNC_ON : SYNC_OFF;
      bright_r <= active_s;
      rgb_r    <= rgb_next_s;
    end
  end

  assign bus.pix_en      = pix_en_s;
  assign bus.hCount      = h_cnt_s;
  assign bus.vCount      = v_cnt_s;
  assign bus.pix_x       = active_s ? (h_cnt_s - H_START_C) : CNT_W'(0);
  assign bus.pix_y       = active_s ? (v_cnt_s - V_START_C) : CNT_W'(0);
  assign bus.active      = active_s;
  assign bus.line_start  = pix_en_s && (h_cnt_s == CNT_W'(0));
  assign bus.frame_start = pix_en_s && (h_cnt_s == CNT_W'(0)) && (v_cnt_s == CNT_W'(0));
  assign bus.hSync       = hsync_r;
  assign bus.vSync       = vsync_r;
  assign bus.bright      = bright_r;
  assign bus.rgb         = rgb_r;
endmodule

// File: tb/tb_vga_display_engine.sv
// Directed bench: a tiny-geometry engine (A, CLK_DIV=2) and a default-geometry
// engine (B, CLK_DIV=1, positive sync) tracked against a reference timing model.
module tb_vga_display_engine;
  import vga_pkg::*;

  localparam int BH_TOT = 800;
  localparam int BV_TOT = 525;
  localparam int BH_S   = 96;
  localparam int BH_ST  = 144;
  localparam int BH_EN  = 783;
  localparam int BV_S   = 2;
  localparam int BV_ST  = 35;
  localparam int BV_EN  = 514;

  typedef struct packed {
    logic [3:0]  fill;
    logic        blank;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_display_engine_if #(.N_LAYERS(4), .COLOR_W(12), .CNT_W(10)) bus_a ();
  vga_display_engine_if #(.N_LAYERS(4), .COLOR_W(12), .CNT_W(10)) bus_b ();

  vga_display_engine #(
    .CLK_DIV(2), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .SYNC_POL(1'b0),
    .N_LAYERS(4), .COLOR_W(12), .BG_COLOR(12'h123), .CNT_W(10)
  ) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

  vga_display_engine #(
    .CLK_DIV(1), .SYNC_POL(1'b1), .N_LAYERS(4), .COLOR_W(12),
    .BG_COLOR(12'h5A5), .CNT_W(10)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference timing model for B (pix_en every clk once running).
  int   m_h;
  int   m_v;
  logic m_run;
  logic m_hs;
  logic m_vs;
  logic m_br;

  always @(posedge clk) begin
    if (rst_b) begin
      m_run <= 1'b0; m_h <= 0; m_v <= 0;
      m_hs <= 1'b0; m_vs <= 1'b0; m_br <= 1'b0;
    end else begin
      m_run <= 1'b1;
      if (m_run) begin
        m_hs <= (m_h < BH_S);
        m_vs <= (m_v < BV_S);
        m_br <= (m_h >= BH_ST) && (m_h <= BH_EN) && (m_v >= BV_ST) && (m_v <= BV_EN);
        if (m_h == BH_TOT - 1) begin
          m_h <= 0;
          m_v <= (m_v == BV_TOT - 1) ? 0 : m_v + 1;
        end else begin
          m_h <= m_h + 1;
        end
      end
    end
  end

  logic mon_b = 1'b0;
  int   b_trk_err = 0;
  int   b_leak = 0;

  always @(negedge clk) begin
    if (mon_b) begin
      if (bus_b.hCount !== 10'(m_h) || bus_b.vCount !== 10'(m_v) ||
          bus_b.hSync !== m_hs || bus_b.vSync !== m_vs ||
          bus_b.bright !== m_br || bus_b.pix_en !== m_run)
        b_trk_err++;
      if (!m_br && bus_b.rgb !== 12'h000)
        b_leak++;
    end
  end

  task automatic wait_b(input int h, input int v, input int lim, input string nm);
    int k = 0;
    while (!(bus_b.hCount == 10'(h) && bus_b.vCount == 10'(v)) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(k < lim), 32'd1);
  endtask

  initial begin
    vec_t vecs [11];
    int   k;
    int   fs [3];
    int   fs_n, hs_lo, vs_lo, br_n, ls_n, rgb_bad, hs_n, vs_n, pe_lo;

    vecs[0]  = '{fill: 4'b0110, blank: 1'b0, rgb: YELLOW};
    vecs[1]  = '{fill: 4'b0000, blank: 1'b0, rgb: 12'h5A5};
    vecs[2]  = '{fill: 4'b0001, blank: 1'b0, rgb: RED};
    vecs[3]  = '{fill: 4'b1000, blank: 1'b0, rgb: GREEN};
    vecs[4]  = '{fill: 4'b1111, blank: 1'b0, rgb: RED};
    vecs[5]  = '{fill: 4'b0100, blank: 1'b0, rgb: BLUE};
    vecs[6]  = '{fill: 4'b1100, blank: 1'b0, rgb: BLUE};
    vecs[7]  = '{fill: 4'b1010, blank: 1'b0, rgb: YELLOW};
    vecs[8]  = '{fill: 4'b0110, blank: 1'b1, rgb: BLACK};
    vecs[9]  = '{fill: 4'b0000, blank: 1'b1, rgb: BLACK};
    vecs[10] = '{fill: 4'b1110, blank: 1'b0, rgb: YELLOW};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.blank_req = 1'b0;
    bus_a.fill = 4'b0000;
    bus_a.layer_color = {WHITE, BLUE, YELLOW, RED};
    bus_b.blank_req = 1'b0;
    bus_b.fill = 4'b1111;
    bus_b.layer_color = {GREEN, BLUE, YELLOW, RED};
    repeat (3) @(negedge clk);

    check("a_rst_hcount", 32'(bus_a.hCount), 32'd0);
    check("a_rst_hsync", 32'(bus_a.hSync), 32'd1);
    check("a_rst_vsync", 32'(bus_a.vSync), 32'd1);
    check("a_rst_pix_en", 32'(bus_a.pix_en), 32'd0);
    check("b_rst_hsync", 32'(bus_b.hSync), 32'd0);
    check("b_rst_rgb", 32'(bus_b.rgb), 32'd0);

    // A: first pix_en after release, then periodic frame measurements.
    rst_a = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_a.pix_en && k < 20);
    check("a_first_pe_clks", 32'(k), 32'd2);
    check("a_first_pe_hcount", 32'(bus_a.hCount), 32'd0);
    check("a_first_frame_start", 32'(bus_a.frame_start), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("a_hcount_step", 32'(bus_a.hCount), 32'd1);

    fs_n = 0; hs_lo = 0; vs_lo = 0; br_n = 0; ls_n = 0; rgb_bad = 0;
    for (int n = 0; n < 288; n++) begin
      @(negedge clk);
      if (bus_a.frame_start) begin
        if (fs_n < 3) fs[fs_n] = n;
        fs_n++;
      end
      if (n < 96) begin
        hs_lo += int'(!bus_a.hSync);
        vs_lo += int'(!bus_a.vSync);
        br_n  += int'(bus_a.bright && bus_a.pix_en);
        ls_n  += int'(bus_a.line_start);
      end
      if (bus_a.bright ? (bus_a.rgb !== 12'h123) : (bus_a.rgb !== 12'h000)) rgb_bad++;
    end
    check("a_frame_start_count", 32'(fs_n), 32'd3);
    check("a_frame_period_1", 32'(fs[1] - fs[0]), 32'd96);
    check("a_frame_period_2", 32'(fs[2] - fs[1]), 32'd96);
    check("a_hsync_clks_per_frame", 32'(hs_lo), 32'd24);
    check("a_vsync_clks_per_frame", 32'(vs_lo), 32'd16);
    check("a_bright_pixels", 32'(br_n), 32'd12);
    check("a_line_starts", 32'(ls_n), 32'd6);
    check("a_rgb_bg_or_black", 32'(rgb_bad), 32'd0);

    // A: reset mid-frame, then restart timing.
    k = 0;
    while (!(bus_a.hCount == 10'd5 && bus_a.vCount == 10'd3) && k < 200) begin
      @(negedge clk); k++;
    end
    check("a_wait_mid_frame", 32'(k < 200), 32'd1);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    check("a_mid_rst_hv", 32'({bus_a.hCount, bus_a.vCount}), 32'd0);
    check("a_mid_rst_sync", 32'({bus_a.hSync, bus_a.vSync}), 32'd3);
    check("a_mid_rst_out", 32'({bus_a.bright, bus_a.rgb, bus_a.pix_en, bus_a.line_start}), 32'd0);
    rst_a = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_a.pix_en && k < 20);
    check("a_mid_first_pe_clks", 32'(k), 32'd2);

    // B: positive sync, CLK_DIV=1, fill all-ones through the porches.
    mon_b = 1'b1;
    rst_b = 1'b0;
    hs_n = 0; vs_n = 0; pe_lo = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n <= 1600) hs_n += int'(bus_b.hSync);
      vs_n  += int'(bus_b.vSync);
      pe_lo += int'(!bus_b.pix_en);
    end
    check("b_pix_en_low_clks", 32'(pe_lo), 32'd0);
    check("b_hsync_high_2lines", 32'(hs_n), 32'd192);
    check("b_vsync_high_clks", 32'(vs_n), 32'd1600);

    wait_b(BH_ST, BV_ST, 40000, "b_wait_first_active");
    check("b_porch_leak", 32'(b_leak), 32'd0);
    for (int i = 0; i < 11; i++) begin
      bus_b.fill = vecs[i].fill;
      bus_b.blank_req = vecs[i].blank;
      check($sformatf("b_vec%0d_pix_x", i), 32'(bus_b.pix_x), 32'(i));
      check($sformatf("b_vec%0d_pix_y", i), 32'(bus_b.pix_y), 32'd0);
      @(negedge clk);
      check($sformatf("b_vec%0d_rgb", i), 32'(bus_b.rgb), 32'(vecs[i].rgb));
      check($sformatf("b_vec%0d_bright", i), 32'(bus_b.bright), 32'd1);
    end

    // B: blank_req raised while pix_x=100 is presented.
    bus_b.fill = 4'b0001;
    bus_b.blank_req = 1'b0;
    wait_b(BH_ST + 100, BV_ST, 200, "b_wait_pix100");
    check("b_pre_blank_rgb", 32'(bus_b.rgb), 32'(RED));
    bus_b.blank_req = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("b_blank_rgb%0d", j), 32'(bus_b.rgb), 32'd0);
    end
    bus_b.blank_req = 1'b0;
    @(negedge clk);
    check("b_unblank_rgb", 32'(bus_b.rgb), 32'(RED));
    bus_b.fill = 4'b0000;
    check("b_timing_vs_model", 32'(b_trk_err), 32'd0);

    // B: reset at (300,36), then porch leakage again with fill all-ones.
    wait_b(300, 36, 2000, "b_wait_reset_point");
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("b_mid_rst_hv", 32'({bus_b.hCount, bus_b.vCount}), 32'd0);
    check("b_mid_rst_out", 32'({bus_b.hSync, bus_b.vSync, bus_b.bright, bus_b.rgb}), 32'd0);
    check("b_mid_rst_strobes", 32'({bus_b.pix_en, bus_b.line_start, bus_b.frame_start}), 32'd0);
    bus_b.fill = 4'b1111;
    rst_b = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_b.pix_en && k < 20);
    check("b_mid_first_pe_clks", 32'(k), 32'd1);
    check("b_mid_first_pe_hcount", 32'(bus_b.hCount), 32'd0);
    @(negedge clk);
    check("b_mid_hcount_step", 32'(bus_b.hCount), 32'd1);
    repeat (2000) @(negedge clk);
    check("b_timing_after_reset", 32'(b_trk_err), 32'd0);
    check("b_leak_after_reset", 32'(b_leak), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_display_engine.md
Name: vga_display_engine

Overview:
- Parametrised successor to the fixed 640x480 display controller.
- Generates VGA timing from a configurable clock divider and a configurable H/V porch/sync geometry.
- Merges N priority-ordered fill layers with a runtime colour palette, then emits registered, mutually aligned sync, blanking and RGB.
- Sits between the game-object renderers (wall, pacman, ghosts, pellets) and the board VGA pins. It also supplies pixel coordinates and frame/line strobes back to those renderers.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1; 4 gives 25 MHz from 100 MHz)
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, horizontal visible pixels
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, vertical visible lines
- V_FP, 10, vertical front porch
- SYNC_POL, 0, asserted level of hSync/vSync (0 = active-low)
- N_LAYERS, 4, number of fill layers (1..8)
- COLOR_W, 12, RGB bus width
- BG_COLOR, 12'h000, colour when no layer fills
- CNT_W, 10, width of the counter and coordinate outputs

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- blank_req  in  1  force black output (active region still timed)
- fill  in  N_LAYERS  per-layer fill for the presented coordinate; bit 0 has highest priority
- layer_color  in  N_LAYERS*COLOR_W  palette; layer i uses slice [i*COLOR_W +: COLOR_W]
- pix_en  out  1  one-clk strobe; counters advance on this cycle
- hCount  out  CNT_W  raw horizontal count, 0..H_TOTAL-1
- vCount  out  CNT_W  raw vertical count, 0..V_TOTAL-1
- pix_x  out  CNT_W  hCount-(H_SYNC+H_BP) when active, else 0
- pix_y  out  CNT_W  vCount-(V_SYNC+V_BP) when active, else 0
- active  out  1  combinational: presented coordinate is visible
- line_start  out  1  pix_en-qualified strobe when hCount==0
- frame_start  out  1  pix_en-qualified strobe when hCount==0 and vCount==0
- hSync  out  1  registered horizontal sync
- vSync  out  1  registered vertical sync
- bright  out  1  registered visible flag, aligned with rgb
- rgb  out  COLOR_W  registered pixel colour

Behaviour:
- Totals:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP
  - V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP
  - Elaboration error if either total exceeds 2^CNT_W.
- Divider:
  - div_cnt runs 0..CLK_DIV-1; pix_en=1 when div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives pix_en tied high after reset.
  - Single clock domain; no derived clocks.
- Counters (only on pix_en):
  - hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount wraps to 0 after V_TOTAL-1, on the same pix_en as the hCount wrap.
- Line layout, in order: sync, back porch, active, front porch.
  - active = hCount in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] AND vCount in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Output pipeline (one pixel of latency):
  - Renderers see hCount/vCount/pix_x/pix_y/active and drive fill combinationally in the same pixel period.
  - On pix_en, the following registers update together:
    - hSync <= (hCount<H_SYNC) ? SYNC_POL : !SYNC_POL; vSync likewise using vCount<V_SYNC.
    - bright <= active.
    - rgb <= colour mux result.
  - Sync, bright and rgb therefore stay aligned, lagging the counters by exactly one pixel.
  - Between pix_en strobes all registered outputs hold.
- Colour mux:
  - !active or blank_req -> 0.
  - Otherwise the lowest-index set fill bit selects its layer_color slice.
  - No fill bit set -> BG_COLOR.
  - fill is ignored outside the active region.
- Strobes: line_start/frame_start are high for exactly the one clk where pix_en=1 and the condition holds.
- Reset, on the cycle after reset is sampled high:
  - div_cnt=0, hCount=0, vCount=0.
  - hSync=vSync=!SYNC_POL, bright=0, rgb=0, pix_en=0, strobes=0.
  - Asserting reset mid-frame restarts at (0,0); the first pix_en arrives CLK_DIV clks after reset deasserts.
- blank_req is sampled only on pix_en; asserting it mid-line blacks the next pixel onward without disturbing timing.

Decomposition:
- vga_pkg holds:
  - default 640x480@60 timing localparams;
  - colour constants BLACK, WHITE, BLUE, RED, GREEN, YELLOW;
  - a function computing totals.
- Sub-module vga_axis_counter(clk, reset, en, wrap_out, count): parametrised by TOTAL.
  - Instantiated twice; the horizontal instance's wrap_out drives the vertical instance's en.

Test Plan:
- Small geometry (CLK_DIV=2, H 2/1/4/1, V 1/1/3/1), no fill -> H_TOTAL=8, V_TOTAL=6. Check:
  - frame_start every 96 clks;
  - hSync asserted for 4 clks per line;
  - bright high for 12 pixels per frame.
- Default params, fill=4'b0110, layer1=12'hFF0, layer2=12'h00F -> rgb=12'hFF0 one pixel after pix_x=0,pix_y=0 is presented; fill=0 -> rgb=BG_COLOR.
- fill held all-ones during porches -> rgb=0 and bright=0 throughout; no layer colour ever leaks.
- blank_req pulsed at pix_x=100 -> rgb=0 from the next registered pixel; hSync/vSync edges unchanged versus a reference run.
- reset asserted at hCount=300,vCount=200 for 3 clks -> all outputs at reset values; first pix_en arrives CLK_DIV clks after release with hCount 0->1.
- SYNC_POL=1, CLK_DIV=1 -> pix_en constantly high; hSync high for exactly H_SYNC clks per line; vSync high for V_SYNC*H_TOTAL clks.
